// File: rtl/bru_pkg.sv
// Shared funct3 encodings and FSM state type for the EX-stage branch resolution unit.
package bru_pkg;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic {
        BRU_IDLE,
        BRU_FLUSH
    } bru_state_t;

endpackage

// File: rtl/br_cond_eval.sv
// Branch condition evaluator: maps funct3 and the comparator's less/equal flags to taken/illegal.
// Purely combinational; the unsigned/signed choice is made upstream in the comparator.
module br_cond_eval
    import bru_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic       less,
    input  logic       equal,
    output logic       taken,
    output logic       illegal
);

    always_comb begin
        taken   = 1'b0;
        illegal = 1'b0;
        case (funct3)
            F3_BEQ:           taken = equal;
            F3_BNE:           taken = !equal;
            F3_BLT, F3_BLTU:  taken = less;
            F3_BGE, F3_BGEU:  taken = !less;
            default:          illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// EX-stage branch/JALR resolution against always-taken prediction; redirect and flushes are registered, one cycle after resolve.
// BRU_PERF_CNT_EN adds saturating resolve/mispredict counters; otherwise the counter ports are tied to 0.
module branch_resolve_unit
    import bru_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_stall,
    input  logic             i_ex_valid,
    input  logic             i_ex_is_br,
    input  logic             i_ex_is_jalr,
    input  logic [2:0]       i_ex_funct3,
    output logic             o_br_un,
    input  logic             i_br_less,
    input  logic             i_br_equal,
    input  logic [XLEN-1:0]  i_ex_pc,
    input  logic [XLEN-1:0]  i_ex_pred_target,
    input  logic [XLEN-1:0]  i_ex_jalr_target,
    output logic             o_redirect,
    output logic [XLEN-1:0]  o_redirect_pc,
    output logic             o_flush_ifid,
    output logic             o_flush_idex,
    output logic             o_br_illegal,
    output logic [CNT_W-1:0] o_br_count,
    output logic [CNT_W-1:0] o_mispred_count
);

    bru_state_t      state;
    logic            taken;
    logic            illegal;
    logic            resolve;
    logic            mispred;
    logic            illegal_hit;
    logic [XLEN-1:0] fix_pc;
    logic [XLEN-1:0] jalr_eff;

    br_cond_eval u_cond (
        .funct3  (i_ex_funct3),
        .less    (i_br_less),
        .equal   (i_br_equal),
        .taken   (taken),
        .illegal (illegal)
    );

    assign o_br_un  = i_ex_funct3[1];
    assign jalr_eff = {i_ex_jalr_target[XLEN-1:1], 1'b0};

    // In FLUSH the EX slot holds a wrong-path instruction, so nothing resolves.
    assign resolve = (state == BRU_IDLE) && i_ex_valid && !i_stall
                     && (i_ex_is_br || i_ex_is_jalr);

    always_comb begin
        mispred     = 1'b0;
        illegal_hit = 1'b0;
        fix_pc      = '0;
        if (resolve) begin
            if (i_ex_is_jalr) begin
                mispred = (jalr_eff != i_ex_pred_target);
                fix_pc  = jalr_eff;
            end else if (illegal) begin
                illegal_hit = 1'b1;
            end else if (!taken) begin
                mispred = 1'b1;
                fix_pc  = i_ex_pc + XLEN'(4);
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state         <= BRU_IDLE;
            o_redirect    <= 1'b0;
            o_redirect_pc <= '0;
            o_flush_ifid  <= 1'b0;
            o_flush_idex  <= 1'b0;
            o_br_illegal  <= 1'b0;
        end else begin
            o_redirect    <= 1'b0;
            o_redirect_pc <= '0;
            o_flush_ifid  <= 1'b0;
            o_flush_idex  <= 1'b0;
            o_br_illegal  <= 1'b0;
            case (state)
                BRU_IDLE: begin
                    o_br_illegal <= illegal_hit;
                    if (mispred) begin
                        state         <= BRU_FLUSH;
                        o_redirect    <= 1'b1;
                        o_redirect_pc <= fix_pc;
                        o_flush_ifid  <= 1'b1;
                        o_flush_idex  <= 1'b1;
                    end
                end
                BRU_FLUSH: state <= BRU_IDLE;
                default:   state <= BRU_IDLE;
            endcase
        end
    end

`ifdef BRU_PERF_CNT_EN
    logic [CNT_W-1:0] br_cnt;
    logic [CNT_W-1:0] mis_cnt;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            br_cnt  <= '0;
            mis_cnt <= '0;
        end else begin
            if (resolve && (br_cnt != '1)) begin
                br_cnt <= br_cnt + CNT_W'(1);
            end
            if (mispred && (mis_cnt != '1)) begin
                mis_cnt <= mis_cnt + CNT_W'(1);
            end
        end
    end

    assign o_br_count      = br_cnt;
    assign o_mispred_count = mis_cnt;
`else
    assign o_br_count      = '0;
    assign o_mispred_count = '0;
`endif

endmodule
